// File: rtl/circle_octants_pkg.sv
// ----------------------------------------------------------------------------
// circle_octants_pkg
//
// Shared definitions for the circle octant point emitter.
//   CORDW_DEF : default signed coordinate width used by the emitter, its
//               handshake interface and the optional clip test.
//   Q0..Q3    : quadrant slot indices; each generator offset pair is turned
//               into one point per slot in this order.
//   quad_t    : type of the quadrant slot counter.
// ----------------------------------------------------------------------------
package circle_octants_pkg;

    localparam int CORDW_DEF = 16;

    typedef logic [1:0] quad_t;

    localparam quad_t Q0 = 2'd0;
    localparam quad_t Q1 = 2'd1;
    localparam quad_t Q2 = 2'd2;
    localparam quad_t Q3 = 2'd3;

endpackage

// File: rtl/circle_octants_if.sv
// ----------------------------------------------------------------------------
// circle_octants_if
//
// Point/offset stream with a valid/oe handshake and an end-of-stream pulse.
// The same bundle is used on both sides of the emitter:
//   - generator side: x/y carry the (xa, ya) offsets, done is the generator's
//     finished pulse and oe is the emitter's enable back to the generator.
//   - pixel side: x/y carry screen points, done is the circle-complete pulse
//     and oe is the pixel writer's ready.
//
// Signals:
//   x, y   signed [CORDW-1:0]  coordinate pair
//   valid  1                   x/y valid
//   oe     1                   consumer ready; transfer on valid && oe
//   done   1                   one-cycle end-of-stream pulse
//
// Modports:
//   master : producer (drives x, y, valid, done; samples oe)
//   slave  : consumer (samples x, y, valid, done; drives oe)
// ----------------------------------------------------------------------------
interface circle_octants_if
    import circle_octants_pkg::*;
#(
    parameter int CORDW = CORDW_DEF
);

    logic signed [CORDW-1:0] x;
    logic signed [CORDW-1:0] y;
    logic                    valid;
    logic                    oe;
    logic                    done;

    modport master (
        output x,
        output y,
        output valid,
        output done,
        input  oe
    );

    modport slave (
        input  x,
        input  y,
        input  valid,
        input  done,
        output oe
    );

endinterface

// File: rtl/circle_octants_point_clip.sv
// ----------------------------------------------------------------------------
// circle_octants_point_clip
//
// Combinational screen-bounds test for one candidate point. The point is
// given in CORDW+1 bits (the untruncated sum) so a coordinate that overflowed
// the output width is still judged by its true value.
//
// Only present when the CIRCLE_CLIP_EN macro is defined; without it this file
// contributes nothing to the build.
//
// Parameters:
//   CORDW  output coordinate width (inputs are CORDW+1 bits)
//   CLIPW  visible width,  x must satisfy 0 <= x < CLIPW
//   CLIPH  visible height, y must satisfy 0 <= y < CLIPH
//
// Ports:
//   px, py  in   signed [CORDW:0]  candidate point
//   inside  out  1                 point lies on screen
// ----------------------------------------------------------------------------
`ifdef CIRCLE_CLIP_EN
module circle_octants_point_clip
    import circle_octants_pkg::*;
#(
    parameter int CORDW = CORDW_DEF,
    parameter int CLIPW = 640,
    parameter int CLIPH = 480
) (
    input  logic signed [CORDW:0] px,
    input  logic signed [CORDW:0] py,
    output logic                  inside
);

    localparam logic signed [CORDW:0] LIM_X = (CORDW+1)'(CLIPW);
    localparam logic signed [CORDW:0] LIM_Y = (CORDW+1)'(CLIPH);

    // The sign bit alone rejects negative coordinates; the upper limit is a
    // signed compare against the clip size at the same width.
    assign inside = !px[CORDW] && (px < LIM_X) &&
                    !py[CORDW] && (py < LIM_Y);

endmodule
`endif

// File: rtl/circle_octants.sv
// ----------------------------------------------------------------------------
// circle_octants
//
// Sits between the circle distance generator and the pixel writer. Each
// (xa, ya) offset pair accepted from the generator is combined with the
// latched centre and emitted as four screen points, one per quadrant:
//   Q0: (cx - xa, cy + ya)     Q1: (cx - ya, cy - xa)
//   Q2: (cx + xa, cy - ya)     Q3: (cx + ya, cy + xa)
// The block owns the generator's oe, so the generator is held while the
// four points of the current pair are still being handed downstream. The
// circle-complete pulse is raised only after the last point has gone.
//
// Optional feature (macro CIRCLE_CLIP_EN):
//   Defined   - points outside 0 <= x < CLIPW, 0 <= y < CLIPH are dropped;
//               a dropped slot costs one cycle and does not wait for oe.
//   Undefined - every point is emitted, coordinates wrap at CORDW bits and
//               CLIPW/CLIPH do not exist.
//
// Parameters:
//   CORDW         signed coordinate width
//   CLIPW, CLIPH  clip window (CIRCLE_CLIP_EN only)
//
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   start   in   latch cx/cy and begin a circle (ignored while busy)
//   cx, cy  in   circle centre
//   gen     slave  generator offsets: x=xa, y=ya, valid, done in; oe out
//                  (oe is combinational)
//   pix     master screen points: x, y, valid, done out; oe in
//   busy    out  circle in progress
// ----------------------------------------------------------------------------
module circle_octants
    import circle_octants_pkg::*;
#(
    parameter int CORDW = CORDW_DEF
`ifdef CIRCLE_CLIP_EN
    ,
    parameter int CLIPW = 640,
    parameter int CLIPH = 480
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [CORDW-1:0] cx,
    input  logic signed [CORDW-1:0] cy,
    circle_octants_if.slave         gen,
    circle_octants_if.master        pix,
    output logic                    busy
);

    // With clipping the range test needs the carry bit of each sum. Without
    // it the carry would be discarded by the truncation anyway, so the sums
    // are formed directly at the output width.
`ifdef CIRCLE_CLIP_EN
    localparam int SUMW = CORDW + 1;
`else
    localparam int SUMW = CORDW;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        EMIT,
        FINISH
    } state_t;

    state_t                  state;
    logic signed [CORDW-1:0] cx_r;
    logic signed [CORDW-1:0] cy_r;
    logic signed [CORDW-1:0] xa_r;
    logic signed [CORDW-1:0] ya_r;
    quad_t                   q;
    logic                    done_pend;

    quad_t                   sel_q;
    logic signed [CORDW-1:0] sel_xa;
    logic signed [CORDW-1:0] sel_ya;
    logic signed [SUMW-1:0]  ecx;
    logic signed [SUMW-1:0]  ecy;
    logic signed [SUMW-1:0]  exa;
    logic signed [SUMW-1:0]  eya;
    logic signed [SUMW-1:0]  pt_x;
    logic signed [SUMW-1:0]  pt_y;
    logic                    keep;
    logic                    slot_free;

    // The generator is only enabled while waiting for a pair. Once its done
    // has been seen no further pair is taken; the block heads for FINISH.
    assign gen.oe = (state == ACCEPT) && gen.valid && !done_pend;

    // A point slot may be replaced when it is empty (clipped) or when its
    // point is being consumed this cycle.
    assign slot_free = !pix.valid || pix.oe;

    // Point for the slot that will be loaded at the next edge: on the
    // handshake it is Q0 of the incoming pair, in EMIT it is the slot after
    // the one currently presented, using the latched pair.
    always_comb begin
        sel_q  = Q0;
        sel_xa = gen.x;
        sel_ya = gen.y;
        if (state == EMIT) begin
            sel_q  = q + 2'd1;
            sel_xa = xa_r;
            sel_ya = ya_r;
        end

        ecx = SUMW'(cx_r);
        ecy = SUMW'(cy_r);
        exa = SUMW'(sel_xa);
        eya = SUMW'(sel_ya);

        pt_x = ecx - exa;
        pt_y = ecy + eya;
        unique case (sel_q)
            Q0: begin
                pt_x = ecx - exa;
                pt_y = ecy + eya;
            end
            Q1: begin
                pt_x = ecx - eya;
                pt_y = ecy - exa;
            end
            Q2: begin
                pt_x = ecx + exa;
                pt_y = ecy - eya;
            end
            Q3: begin
                pt_x = ecx + eya;
                pt_y = ecy + exa;
            end
        endcase
    end

`ifdef CIRCLE_CLIP_EN
    circle_octants_point_clip #(
        .CORDW (CORDW),
        .CLIPW (CLIPW),
        .CLIPH (CLIPH)
    ) u_point_clip (
        .px     (pt_x),
        .py     (pt_y),
        .inside (keep)
    );
`else
    assign keep = 1'b1;
`endif

    // Control FSM with registered point, busy and done outputs.
    // The generator's done pulse can land while points are still pending
    // (the generator finishes a couple of cycles after its last oe), so it
    // is remembered in done_pend and only acted on back in ACCEPT, once the
    // final pair has been fully drained. done and busy change on entry to
    // FINISH so that done is high for exactly the one FINISH cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cx_r      <= '0;
            cy_r      <= '0;
            xa_r      <= '0;
            ya_r      <= '0;
            q         <= Q0;
            done_pend <= 1'b0;
            busy      <= 1'b0;
            pix.x     <= '0;
            pix.y     <= '0;
            pix.valid <= 1'b0;
            pix.done  <= 1'b0;
        end else begin
            if (gen.done) begin
                done_pend <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    pix.done <= 1'b0;
                    if (start) begin
                        cx_r  <= cx;
                        cy_r  <= cy;
                        busy  <= 1'b1;
                        state <= ACCEPT;
                    end
                end

                ACCEPT: begin
                    if (done_pend) begin
                        pix.done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= FINISH;
                    end else if (gen.oe) begin
                        xa_r      <= gen.x;
                        ya_r      <= gen.y;
                        q         <= Q0;
                        pix.x     <= pt_x[CORDW-1:0];
                        pix.y     <= pt_y[CORDW-1:0];
                        pix.valid <= keep;
                        state     <= EMIT;
                    end
                end

                EMIT: begin
                    if (slot_free) begin
                        if (q == Q3) begin
                            pix.valid <= 1'b0;
                            state     <= ACCEPT;
                        end else begin
                            q         <= sel_q;
                            pix.x     <= pt_x[CORDW-1:0];
                            pix.y     <= pt_y[CORDW-1:0];
                            pix.valid <= keep;
                        end
                    end
                end

                FINISH: begin
                    pix.done  <= 1'b0;
                    done_pend <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
